sw_input_conditioner: RTL
=========================

Name: sw_input_conditioner

Overview:
- Front-end stage that feeds the switch-driven sequence FSM.
- Takes raw, bouncing, asynchronous slide and push switches. Produces synchronized, debounced switch levels, plus one-cycle press pulses that are only raised when exactly one switch is active.
- Its sw_clean outputs drive the FSM's SW inputs directly. sw_pulse and multi_press are available for edge-triggered consumers and for status LEDs.

Parameters:
- N_SW, 4, number of switch channels.
- DEBOUNCE_CYCLES, 16, consecutive cycles an input must differ from its clean value before the clean value changes. Must be ≥2.
- SYNC_STAGES, 2, flip-flop depth of the input synchronizer. Must be ≥2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sw_raw  in  N_SW  raw switch inputs, asynchronous to clk.
- sw_clean  out  N_SW  debounced switch levels.
- sw_pulse  out  N_SW  one-cycle, one-hot press pulse.
- multi_press  out  1  high while more than one sw_clean bit is set.

Behaviour:
- Reset (async, any time, including mid-count):
  - synchronizer flops, counters, sw_clean, sw_pulse, multi_press all go to 0.
  - lockout (if compiled in) is cleared.
- Synchronizer: each bit passes through SYNC_STAGES flops; the output is s[i].
- Debounce, per channel:
  - Counter width is $clog2(DEBOUNCE_CYCLES).
  - Each edge with s[i] != sw_clean[i]:
    - if cnt == DEBOUNCE_CYCLES-1: sw_clean[i] <= s[i], cnt <= 0;
    - else cnt++.
  - Each edge with s[i] == sw_clean[i]: cnt <= 0. Any bounce restarts the count.
- Channel FSM states:
  - LO_STABLE → LO_PEND when s=1.
  - LO_PEND → HI_STABLE on count done.
  - LO_PEND → LO_STABLE when s=0.
  - HI_STABLE / HI_PEND mirror the above.
- Latency: sw_clean changes on the (SYNC_STAGES+DEBOUNCE_CYCLES)-th rising edge after sw_raw changes (the first sampling edge counts as 1).
- Pulse:
  - Registered. sw_pulse[i]=1 for exactly one cycle, on the edge after sw_clean[i] rises.
  - Condition: sw_clean (post-rise) == only bit i set.
  - Otherwise no pulse. A rise that creates a multi-press never pulses.
  - A later release of the other switches does not produce a retroactive pulse.
- Simultaneous rises on two channels in the same cycle: no pulse.
- multi_press: registered, = (popcount(sw_clean) > 1), same timing as sw_pulse.
- Falling edges never pulse.
- sw_raw held high through reset: clean rises SYNC_STAGES+DEBOUNCE_CYCLES edges after reset deasserts, then a normal pulse follows.

Optional Feature:
- SW_LOCKOUT_EN.
- Defined:
  - After any sw_pulse, further pulses are suppressed until sw_clean == 0 for at least one cycle.
  - multi_press is unaffected.
- Undefined: each qualifying rise pulses independently.

Decomposition:
- Package sw_cond_pkg holds:
  - enum deb_state_t {LO_STABLE, LO_PEND, HI_STABLE, HI_PEND};
  - default constants for N_SW, DEBOUNCE_CYCLES, SYNC_STAGES;
  - function onehot_idx for pulse qualification.
- Sub-module sw_debounce_ch: one channel with synchronizer, counter, FSM and sw_clean bit. It is instantiated N_SW times via generate.
- The top level holds pulse qualification, multi_press and lockout.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
- Clean press: sw_raw=4'b0001 before edge 1 → sw_clean=0001 after edge 6; sw_pulse=0001 after edge 7 only; multi_press stays 0.
- Bounce:
  - sw_raw[1] toggles 1,0,1,0 on successive cycles, then holds 1 → sw_clean[1] rises 6 edges after the final 0→1.
  - sw_raw[1] high for 2 cycles only → no change, no pulse.
- Multi-press:
  - sw_raw 0001 settled, then 0101 → sw_clean=0101, sw_pulse never 0100, multi_press=1.
  - Release 0001 → multi_press=0, no pulse.
- Simultaneous: sw_raw 0000→0011 in one cycle → no pulse, multi_press=1 after edge 7.
- Reset mid-count: sw_raw=0010, reset pulsed at edge 4 → all outputs 0; after release with raw still 0010, sw_clean=0010 on edge 6 post-reset, pulse on edge 7.
- Lockout (SW_LOCKOUT_EN): press 0001, release to 0000 less than debounce time then 0010 → pulse 0001 then 0010 only if sw_clean reached 0000 in between; otherwise 0010 is suppressed.

Source files
------------

// File: rtl/sw_cond_pkg.sv
// Shared types, default sizing and helpers for the switch input conditioner.
package sw_cond_pkg;

  typedef enum logic [1:0] {
    LO_STABLE = 2'd0,
    LO_PEND   = 2'd1,
    HI_STABLE = 2'd2,
    HI_PEND   = 2'd3
  } deb_state_t;

  localparam int unsigned NSwDefault            = 4;
  localparam int unsigned DebounceCyclesDefault = 16;
  localparam int unsigned SyncStagesDefault     = 2;
  localparam int unsigned MaxSw                 = 32;

  // Index of the single set bit, or -1 when zero or several bits are set.
  function automatic int onehot_idx(input logic [MaxSw-1:0] v);
    int          idx;
    int unsigned n;
    idx = -1;
    n   = 0;
    for (int i = 0; i < MaxSw; i++) begin
      if (v[i]) begin
        idx = i;
        n++;
      end
    end
    return (n == 1) ? idx : -1;
  endfunction

endpackage

// File: rtl/sw_debounce_ch.sv
// One switch channel: synchronizer, stability counter and debounce FSM.
module sw_debounce_ch
  import sw_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault,
  parameter int unsigned SYNC_STAGES     = SyncStagesDefault
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_raw_i,
  output logic sw_clean_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntDone = CntW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CntW-1:0]        cnt_q;
  deb_state_t             state_q;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      state_q <= LO_STABLE;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sw_raw_i};
      unique case (state_q)
        LO_STABLE: begin
          if (s) begin
            state_q <= LO_PEND;
            cnt_q   <= CntW'(1);
          end else begin
            cnt_q <= '0;
          end
        end
        LO_PEND: begin
          if (!s) begin
            state_q <= LO_STABLE;
            cnt_q   <= '0;
          end else if (cnt_q == CntDone) begin
            state_q <= HI_STABLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        HI_STABLE: begin
          if (!s) begin
            state_q <= HI_PEND;
            cnt_q   <= CntW'(1);
          end else begin
            cnt_q <= '0;
          end
        end
        HI_PEND: begin
          if (s) begin
            state_q <= HI_STABLE;
            cnt_q   <= '0;
          end else if (cnt_q == CntDone) begin
            state_q <= LO_STABLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: begin
          state_q <= LO_STABLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign sw_clean_o = (state_q == HI_STABLE) || (state_q == HI_PEND);

endmodule

// File: rtl/sw_input_conditioner.sv
// Debounced switch levels plus one-hot press pulses and multi-press flag.
// Define SW_LOCKOUT_EN to suppress further pulses until all switches are released.
module sw_input_conditioner
  import sw_cond_pkg::*;
#(
  parameter int unsigned N_SW            = NSwDefault,
  parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault,
  parameter int unsigned SYNC_STAGES     = SyncStagesDefault
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_SW-1:0] sw_raw_i,
  output logic [N_SW-1:0] sw_clean_o,
  output logic [N_SW-1:0] sw_pulse_o,
  output logic            multi_press_o
);

  logic [N_SW-1:0] clean;
  logic [N_SW-1:0] clean_prev_q;
  logic [N_SW-1:0] rise;
  logic [N_SW-1:0] pulse_d, pulse_q;
  logic            multi_d, multi_q;
  int              idx;
  int unsigned     ones;

  for (genvar g = 0; g < N_SW; g++) begin : g_ch
    sw_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .sw_raw_i  (sw_raw_i[g]),
      .sw_clean_o(clean[g])
    );
  end

`ifdef SW_LOCKOUT_EN
  logic lock_d, lock_q;
`endif

  always_comb begin
    rise    = clean & ~clean_prev_q;
    idx     = onehot_idx(MaxSw'(clean));
    pulse_d = '0;
    ones    = 0;
    // Only the bit that just rose may pulse, and only if it is the sole active switch.
    for (int i = 0; i < N_SW; i++) begin
      if (rise[i] && (idx == i)) pulse_d[i] = 1'b1;
      ones = ones + {31'd0, clean[i]};
    end
    multi_d = (ones > 1);
`ifdef SW_LOCKOUT_EN
    if (lock_q) pulse_d = '0;
    if (clean == '0) lock_d = 1'b0;
    else if (|pulse_d) lock_d = 1'b1;
    else lock_d = lock_q;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clean_prev_q <= '0;
      pulse_q      <= '0;
      multi_q      <= 1'b0;
`ifdef SW_LOCKOUT_EN
      lock_q       <= 1'b0;
`endif
    end else begin
      clean_prev_q <= clean;
      pulse_q      <= pulse_d;
      multi_q      <= multi_d;
`ifdef SW_LOCKOUT_EN
      lock_q       <= lock_d;
`endif
    end
  end

  assign sw_clean_o    = clean;
  assign sw_pulse_o    = pulse_q;
  assign multi_press_o = multi_q;

endmodule
